vram_dump: RTL and testbench

VRAM_DUMP -- requirements
Module: vram_dump

---
 rtl/vdp_pkg.sv | 27 ++
 rtl/vram_dump.sv | 154 +++++++++++++++
 tb/tb_vram_dump.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vdp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : vdp_pkg                                                     |
// | Brief   : Shared state encodings and VRAM timing constants for the    |
// |           VRAM-to-UART dump engine.                                   |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package vdp_pkg;

  // Cycles between presenting an address to the VRAM and its data appearing.
  localparam int unsigned VRAM_RD_LAT = 1;

  // Width of the counter that spans the VRAM read latency.
  localparam int unsigned LAT_W = (VRAM_RD_LAT > 1) ? $clog2(VRAM_RD_LAT) : 1;

  // Dump sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_LOAD      = 3'd2,
    ST_WAIT_TX   = 3'd3,
    ST_CSUM      = 3'd4,
    ST_CSUM_WAIT = 3'd5
  } dump_state_e;

endpackage : vdp_pkg
`default_nettype wire

// File: rtl/vram_dump.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : vram_dump                                                   |
// | Brief   : Streams a block of VRAM bytes to a UART transmitter,        |
// |           followed by an 8-bit additive checksum byte.                |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module vram_dump
  import vdp_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [7:0]        vram_do,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  input  logic              tx_done,
  output logic              busy,
  output logic              done
);

  dump_state_e       state_q,   state_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [LEN_W-1:0]  count_q,   count_d;
  logic [7:0]        sum_q,     sum_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_wr_q,   tx_wr_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic [LAT_W-1:0]  lat_q,     lat_d;

  // A tx_done arriving in the same cycle as our own strobe belongs to an
  // earlier byte, so it is never taken as completion of the current one.
  logic tx_done_ok;
  assign tx_done_ok = tx_done && !tx_wr_q;

  // Next-state and next-output computation for the dump sequencer.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    sum_d     = sum_q;
    tx_data_d = tx_data_q;
    tx_wr_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    lat_d     = lat_q;

    if (abort) begin
      // Abort overrides everything, including a start in IDLE.
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      lat_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_d  = base_addr;
            count_d = length;
            sum_d   = 8'h00;
            busy_d  = 1'b1;
            lat_d   = '0;
            state_d = (length != '0) ? ST_FETCH : ST_CSUM;
          end
        end

        ST_FETCH: begin
          // Hold the address until the synchronous RAM has produced data.
          if (lat_q == LAT_W'(VRAM_RD_LAT - 1)) begin
            lat_d   = '0;
            state_d = ST_LOAD;
          end else begin
            lat_d = lat_q + LAT_W'(1);
          end
        end

        ST_LOAD: begin
          tx_data_d = vram_do;
          sum_d     = sum_q + vram_do;
          tx_wr_d   = 1'b1;
          state_d   = ST_WAIT_TX;
        end

        ST_WAIT_TX: begin
          if (tx_done_ok) begin
            addr_d  = addr_q + ADDR_W'(1);
            count_d = count_q - LEN_W'(1);
            lat_d   = '0;
            state_d = (count_q == LEN_W'(1)) ? ST_CSUM : ST_FETCH;
          end
        end

        ST_CSUM: begin
          tx_data_d = sum_q;
          tx_wr_d   = 1'b1;
          state_d   = ST_CSUM_WAIT;
        end

        ST_CSUM_WAIT: begin
          if (tx_done_ok) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      sum_q     <= 8'h00;
      tx_data_q <= 8'h00;
      tx_wr_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lat_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lat_q     <= lat_d;
    end
  end

  assign vram_addr = addr_q;
  assign tx_data   = tx_data_q;
  assign tx_wr     = tx_wr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule : vram_dump
`default_nettype wire

// File: tb/tb_vram_dump.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module  : tb_vram_dump                                                |
// | Brief   : Self-checking bench for vram_dump with VRAM and UART models |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_vram_dump;

  localparam int ADDR_W = 14;
  localparam int LEN_W  = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_do;
  logic [7:0]        tx_data;
  logic              tx_wr;
  logic              tx_done;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  vram_dump #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .length    (length),
    .vram_addr (vram_addr),
    .vram_do   (vram_do),
    .tx_data   (tx_data),
    .tx_wr     (tx_wr),
    .tx_done   (tx_done),
    .busy      (busy),
    .done      (done)
  );

  // Synchronous-read VRAM model.
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) vram_do <= mem[vram_addr];

  // Scoreboard entries: byte expected on tx_data and address expected on vram_addr.
  typedef struct {
    logic [7:0]        data;
    logic [ADDR_W-1:0] addr;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Output monitor: every transmit strobe is matched against the scoreboard.
  always @(negedge clk) begin
    if (tx_wr === 1'b1) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_tx_wr", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        check("tx_data", 32'(tx_data), 32'(e.data));
        check("tx_addr", 32'(vram_addr), 32'(e.addr));
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  // UART model: tx_done pulse sampled on the 10th rising edge after tx_wr.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_wr === 1'b1) begin
        repeat (9) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic [7:0]        data [5];
    logic [7:0]        csum;
  } vec_t;
  vec_t vecs [4];

  // Loads memory for a dump and queues the bytes it must produce.
  task automatic load_dump(input logic [ADDR_W-1:0] b, input int n, input logic [7:0] first,
                           input logic [7:0] step);
    logic [7:0] s;
    logic [7:0] v;
    s = 8'h00;
    v = first;
    for (int i = 0; i < n; i++) begin
      mem[ADDR_W'(int'(b) + i)] = v;
      sb.push_back('{data: v, addr: ADDR_W'(int'(b) + i)});
      s = s + v;
      v = v + step;
    end
    sb.push_back('{data: s, addr: ADDR_W'(int'(b) + n)});
  endtask

  task automatic wait_wr(input int target, input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (wr_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(name, 32'(ok), 32'(1));
  endtask

  int d0;
  int w0;
  int lat;
  bit seen;

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = '0;
    length    = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;

    vecs[0] = '{base: 14'h0100, len: 15'd4, data: '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00}, csum: 8'h0A};
    vecs[1] = '{base: 14'h3FFE, len: 15'd3, data: '{8'hFF, 8'h80, 8'h02, 8'h00, 8'h00}, csum: 8'h81};
    vecs[2] = '{base: 14'h0200, len: 15'd0, data: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, csum: 8'h00};
    vecs[3] = '{base: 14'h0200, len: 15'd5, data: '{8'h10, 8'h20, 8'h30, 8'h40, 8'hF0}, csum: 8'h90};

    // Reset state
    tick();
    tick();
    check("rst_vram_addr", 32'(vram_addr), 32'(0));
    check("rst_tx_data",   32'(tx_data),   32'(0));
    check("rst_tx_wr",     32'(tx_wr),     32'(0));
    check("rst_busy",      32'(busy),      32'(0));
    check("rst_done",      32'(done),      32'(0));
    rst_n = 1'b1;
    tick();
    tick();

    // Table-driven dumps
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < int'(vecs[v].len); i++) begin
        mem[ADDR_W'(int'(vecs[v].base) + i)] = vecs[v].data[i];
        sb.push_back('{data: vecs[v].data[i], addr: ADDR_W'(int'(vecs[v].base) + i)});
      end
      sb.push_back('{data: vecs[v].csum, addr: ADDR_W'(int'(vecs[v].base) + int'(vecs[v].len))});
      d0        = done_cnt;
      base_addr = vecs[v].base;
      length    = vecs[v].len;
      start     = 1'b1;
      lat       = (vecs[v].len != '0) ? 3 : 2;
      for (int k = 1; k <= lat; k++) begin
        tick();
        if (k == 1) begin
          start     = 1'b0;
          base_addr = '1;
          length    = 15'd9;
          check("busy_after_start", 32'(busy), 32'(1));
        end
        check("tx_wr_latency", 32'(tx_wr), 32'(k == lat));
      end
      seen = 1'b0;
      for (int c = 0; c < 600; c++) begin
        if (done === 1'b1) begin
          seen = 1'b1;
          break;
        end
        tick();
      end
      check("done_seen", 32'(seen), 32'(1));
      check("busy_at_done", 32'(busy), 32'(0));
      tick();
      tick();
      check("done_once", 32'(done_cnt - d0), 32'(1));
      check("sb_empty", 32'(sb.size()), 32'(0));
      check("busy_after", 32'(busy), 32'(0));
    end

    // Abort during WAIT_TX of byte 2 of an 8-byte dump
    load_dump(14'h0400, 8, 8'h11, 8'h01);
    w0        = wr_cnt;
    d0        = done_cnt;
    base_addr = 14'h0400;
    length    = 15'd8;
    start     = 1'b1;
    tick();
    start = 1'b0;
    wait_wr(w0 + 2, "abort_reach_byte2");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_tx_wr", 32'(tx_wr), 32'(0));
    sb.delete();
    repeat (30) tick();
    check("abort_no_done", 32'(done_cnt - d0), 32'(0));
    check("abort_no_more_wr", 32'(wr_cnt), 32'(w0 + 2));
    check("abort_idle_busy", 32'(busy), 32'(0));

    // Start and abort in the same IDLE cycle
    w0    = wr_cnt;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'(0));
    repeat (10) tick();
    check("start_abort_no_wr", 32'(wr_cnt), 32'(w0));

    // Second start mid-dump ignored, then asynchronous reset mid-dump
    load_dump(14'h0500, 8, 8'hA0, 8'h03);
    w0        = wr_cnt;
    d0        = done_cnt;
    base_addr = 14'h0500;
    length    = 15'd8;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    base_addr = 14'h0100;
    length    = 15'd1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check("restart_busy", 32'(busy), 32'(1));
    wait_wr(w0 + 3, "reset_reach_byte3");
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_vram_addr", 32'(vram_addr), 32'(0));
    check("async_tx_data",   32'(tx_data),   32'(0));
    check("async_tx_wr",     32'(tx_wr),     32'(0));
    check("async_busy",      32'(busy),      32'(0));
    check("async_done",      32'(done),      32'(0));
    sb.delete();
    w0 = wr_cnt;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("post_reset_no_wr", 32'(wr_cnt), 32'(w0));
    check("post_reset_busy", 32'(busy), 32'(0));
    check("post_reset_no_done", 32'(done_cnt - d0), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_vram_dump
`default_nettype wire
